wah_update_sequencer: RTL and testbench

Parametrised, multi-channel coefficient-update sequencer for the wah effect path. It generates the sample tick from `system_clock` and walks a single shared coefficient unit across `NUM_CH` channels with a start/ready handshake. Results are captured into a shadow bank and swapped atomically into the active bank on the next sample tick, so the filter pipelines never see a half-updated coefficient set. Sits between `cutoff_freq_unit`/`coefficient_unit` and the per-channel `filter_pipeline` instances.

---
 rtl/wah_update_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_wah_update_sequencer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wah_update_sequencer.sv
// wah_update_sequencer
//   Generates the audio sample tick from system_clock and walks one shared
//   coefficient unit over NUM_CH channels. Each result lands in a shadow
//   bank; the whole shadow bank is copied to the active bank on the next
//   sample tick, so the filter pipelines only ever see complete sets.
//
// Ports
//   system_clock  sole clock
//   rst_n         asynchronous active-low reset
//   enable        allows new rounds to start
//   sample_tick   one-cycle pulse every CLK_DIV cycles
//   coeff_start   request to the coefficient unit, held until coeff_ready
//   coeff_ch      channel currently requested
//   coeff_ready   one-cycle result-valid pulse from the coefficient unit
//   coeff_in      {b0,b1,b2,a0,a1,a2}, b0 in the MSBs
//   coeff_out     active bank, channel 0 in the LSBs
//   bank_swap     one-cycle pulse when the active bank is updated
//   ready_out     one-cycle pulse when a round has captured all channels
//   overrun       sticky: a tick arrived while a round was still running
//   timeout_err   sticky watchdog flag (0 unless WAH_SEQ_TIMEOUT_EN)
//   clear_flags   synchronous clear of overrun/timeout_err (a set wins)
//
// Build option
//   WAH_SEQ_TIMEOUT_EN  adds a per-channel handshake watchdog that aborts
//                       the round after TIMEOUT_CYCLES without coeff_ready.
module wah_update_sequencer #(
  parameter int NUM_CH         = 2,
  parameter int COEFF_WIDTH    = 24,
  parameter int FRAC_BITS      = 16,
  parameter int CLK_DIV        = 1000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                       system_clock,
  input  logic                                       rst_n,
  input  logic                                       enable,
  output logic                                       sample_tick,
  output logic                                       coeff_start,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] coeff_ch,
  input  logic                                       coeff_ready,
  input  logic [6*COEFF_WIDTH-1:0]                   coeff_in,
  output logic [NUM_CH*6*COEFF_WIDTH-1:0]            coeff_out,
  output logic                                       bank_swap,
  output logic                                       ready_out,
  output logic                                       overrun,
  output logic                                       timeout_err,
  input  logic                                       clear_flags
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W  = 6 * COEFF_WIDTH;
  localparam int BANK_W = NUM_CH * SET_W;
  localparam int CNT_W  = $clog2(CLK_DIV);

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_WAIT_SWAP = 2'd2;

  // Pass-through biquad for every channel: b0 = a0 = 1.0, everything else 0.
  function automatic logic [BANK_W-1:0] identity_bank();
    logic [SET_W-1:0]  one_set;
    logic [BANK_W-1:0] bank;
    one_set = '0;
    one_set[5*COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(1) << FRAC_BITS;
    one_set[2*COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(1) << FRAC_BITS;
    for (int c = 0; c < NUM_CH; c++) begin
      bank[c*SET_W +: SET_W] = one_set;
    end
    return bank;
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              start_q, start_d;
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              ready_out_q, ready_out_d;
  logic              bank_swap_q, bank_swap_d;
  logic              overrun_q, overrun_d;
  logic              ovr_set;
  logic              tick;

  assign tick = (cnt_q == LAST_CNT);

`ifdef WAH_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            tmo_set;
`endif

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    state_d     = state_q;
    ch_d        = ch_q;
    start_d     = start_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    ready_out_d = 1'b0;
    bank_swap_d = 1'b0;
    ovr_set     = 1'b0;
`ifdef WAH_SEQ_TIMEOUT_EN
    tmo_set     = 1'b0;
    // Watchdog restarts for every channel; it only runs while a request is up.
    wd_d        = (state_q == S_REQ && start_q && !coeff_ready) ? wd_q + WD_W'(1) : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          state_d = S_REQ;
          ch_d    = '0;
          start_d = 1'b1;
        end
      end
      S_REQ: begin
        // The tick is lost; the swap waits for the tick after capture ends.
        if (tick) ovr_set = 1'b1;
        if (start_q && coeff_ready) begin
          shadow_d[int'(ch_q)*SET_W +: SET_W] = coeff_in;
          start_d = 1'b0;
          if (ch_q == LAST_CH) begin
            ready_out_d = 1'b1;
            state_d     = S_WAIT_SWAP;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
`ifdef WAH_SEQ_TIMEOUT_EN
        else if (start_q && wd_q == WD_LAST) begin
          // Abort: active bank untouched, partial shadow never swapped in.
          start_d = 1'b0;
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end
`endif
        else if (!start_q) begin
          // Re-request one cycle after the previous capture.
          start_d = 1'b1;
        end
      end
      S_WAIT_SWAP: begin
        if (tick) begin
          active_d    = shadow_q;
          bank_swap_d = 1'b1;
          if (enable) begin
            state_d = S_REQ;
            ch_d    = '0;
            start_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    overrun_d = ovr_set | (overrun_q & ~clear_flags);
`ifdef WAH_SEQ_TIMEOUT_EN
    timeout_d = tmo_set | (timeout_q & ~clear_flags);
`endif
  end

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      ch_q        <= '0;
      start_q     <= 1'b0;
      shadow_q    <= identity_bank();
      active_q    <= identity_bank();
      ready_out_q <= 1'b0;
      bank_swap_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      start_q     <= start_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      ready_out_q <= ready_out_d;
      bank_swap_q <= bank_swap_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef WAH_SEQ_TIMEOUT_EN
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign sample_tick = tick;
  assign coeff_start = start_q;
  assign coeff_ch    = ch_q;
  assign coeff_out   = active_q;
  assign bank_swap   = bank_swap_q;
  assign ready_out   = ready_out_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_wah_update_sequencer.sv
module tb_wah_update_sequencer;

  localparam int NUM_CH  = 2;
  localparam int CW      = 24;
  localparam int FB      = 16;
  localparam int CLK_DIV = 16;
  localparam int TMO     = 8;
  localparam int SETW    = 6 * CW;
  localparam int BANKW   = NUM_CH * SETW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              coeff_ready = 1'b0;
  logic [SETW-1:0]   coeff_in = '0;
  logic              clear_flags = 1'b0;
  logic              sample_tick, coeff_start, bank_swap, ready_out, overrun, timeout_err;
  logic [0:0]        coeff_ch;
  logic [BANKW-1:0]  coeff_out;

  int checks = 0;
  int errors = 0;
  logic [BANKW-1:0] exp_q[$];
  int   resp_delay = 3;
  bit   resp_en = 1'b1;
  int   pat_base = 0;
  int   ready_cnt = 0;
  logic prev_tick = 1'b0;

  wah_update_sequencer #(
    .NUM_CH(NUM_CH), .COEFF_WIDTH(CW), .FRAC_BITS(FB),
    .CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clock(clk), .rst_n(rst_n), .enable(enable),
    .sample_tick(sample_tick), .coeff_start(coeff_start), .coeff_ch(coeff_ch),
    .coeff_ready(coeff_ready), .coeff_in(coeff_in), .coeff_out(coeff_out),
    .bank_swap(bank_swap), .ready_out(ready_out), .overrun(overrun),
    .timeout_err(timeout_err), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [BANKW-1:0] ident();
    logic [BANKW-1:0] b;
    b = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      b[c*SETW + 5*CW +: CW] = 24'h010000;
      b[c*SETW + 2*CW +: CW] = 24'h010000;
    end
    return b;
  endfunction

  // Channel c of a round with base value: elements base + 16*c + 1 .. +6, b0 first.
  function automatic logic [SETW-1:0] pat_set(input int base, input int c);
    logic [SETW-1:0] s;
    for (int k = 0; k < 6; k++) s[(5-k)*CW +: CW] = CW'(base + 16*c + k + 1);
    return s;
  endfunction

  function automatic logic [BANKW-1:0] pat_bank(input int base);
    logic [BANKW-1:0] b;
    for (int c = 0; c < NUM_CH; c++) b[c*SETW +: SETW] = pat_set(base, c);
    return b;
  endfunction

  // Coefficient-unit model: answers each request resp_delay cycles after it appears.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (coeff_ready) begin
        coeff_ready = 1'b0;
      end else if (coeff_start && resp_en && rst_n) begin
        wait_cnt++;
        if (wait_cnt >= resp_delay) begin
          coeff_in    = pat_set(pat_base, int'(coeff_ch));
          coeff_ready = 1'b1;
          wait_cnt    = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: every bank_swap must expose the next expected bank,
  // one cycle after sample_tick.
  initial begin
    logic [BANKW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ready_out) ready_cnt++;
      if (rst_n && bank_swap) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL swap_unexpected: got bank %h, required no swap", coeff_out);
        end else begin
          e = exp_q.pop_front();
          if (coeff_out !== e) begin
            errors++;
            $display("FAIL swap_bank: got %h, required %h", coeff_out, e);
          end
        end
        checks++;
        if (prev_tick !== 1'b1) begin
          errors++;
          $display("FAIL swap_timing: sample_tick one cycle earlier was %b, required 1", prev_tick);
        end
      end
      prev_tick = sample_tick;
    end
  end

  // which: 0 bank_swap, 1 ready_out, 2 coeff_start, 3 sample_tick
  task automatic wait_sig(input int which, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (which)
        0: seen = bank_swap;
        1: seen = ready_out;
        2: seen = coeff_start;
        default: seen = sample_tick;
      endcase
      if (seen) return;
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    rst_n = 1'b0;
    enable = 1'b0;
    #12;
    checks++;
    if ({sample_tick, coeff_start, coeff_ch, bank_swap, ready_out, overrun, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {sample_tick, coeff_start, coeff_ch, bank_swap, ready_out, overrun, timeout_err});
    end
    checks++;
    if (coeff_out !== ident()) begin
      errors++;
      $display("FAIL reset_bank: got %h, required %h", coeff_out, ident());
    end
    // Cycle 1 is the cycle in which rst_n rises.
    @(negedge clk);
    rst_n = 1'b1;
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sample_tick) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != CLK_DIV) begin
      errors++;
      $display("FAIL first_tick: seen=%0d at cycle %0d, required cycle %0d", seen, n, CLK_DIV);
    end
    @(negedge clk);
    checks++;
    if (sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL tick_width: got %b one cycle later, required 0", sample_tick);
    end
  endtask

  task automatic test_round();
    int chs[4];
    int ns, r0;
    logic prev_s, prev_t;
    bit got_ready, seen;
    pat_base = 0;
    resp_delay = 3;
    r0 = ready_cnt;
    exp_q.push_back(pat_bank(0));
    enable = 1'b1;
    ns = 0;
    prev_s = 1'b0;
    prev_t = 1'b0;
    got_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (coeff_start && !prev_s) begin
        if (ns == 0) begin
          checks++;
          if (prev_t !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: tick one cycle before start was %b, required 1", prev_t);
          end
        end
        if (ns < 4) chs[ns] = int'(coeff_ch);
        ns++;
      end
      if (coeff_start) enable = 1'b0;
      if (ready_out) begin
        got_ready = 1'b1;
        break;
      end
      prev_s = coeff_start;
      prev_t = sample_tick;
    end
    checks++;
    if (!got_ready || ns != 2 || chs[0] != 0 || chs[1] != 1) begin
      errors++;
      $display("FAIL round_channels: ready=%0d starts=%0d ch=%0d,%0d required ready=1 starts=2 ch=0,1",
               got_ready, ns, chs[0], chs[1]);
    end
    checks++;
    if (coeff_out !== ident()) begin
      errors++;
      $display("FAIL bank_held_before_tick: got %h, required %h", coeff_out, ident());
    end
    wait_sig(0, 40, seen);
    checks++;
    if (!seen || coeff_out !== pat_bank(0)) begin
      errors++;
      $display("FAIL round_swap: seen=%0d bank %h, required %h", seen, coeff_out, pat_bank(0));
    end
    checks++;
    if (ready_cnt - r0 != 1) begin
      errors++;
      $display("FAIL ready_pulses: got %0d, required 1", ready_cnt - r0);
    end
    wait_sig(2, CLK_DIV + 4, seen);
    checks++;
    if (seen || overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_round: start=%0d overrun=%b, required 0 and 0", seen, overrun);
    end
  endtask

  task automatic test_overrun();
    bit seen;
    pat_base = 'h40;
    resp_delay = 20;
    exp_q.push_back(pat_bank('h40));
    enable = 1'b1;
    wait_sig(2, 40, seen);
    enable = 1'b0;
    wait_sig(1, 100, seen);
    checks++;
    if (!seen || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: ready=%0d overrun=%b, required 1 and 1", seen, overrun);
    end
    checks++;
    if (coeff_out !== pat_bank(0)) begin
      errors++;
      $display("FAIL overrun_bank_held: got %h, required %h", coeff_out, pat_bank(0));
    end
    wait_sig(0, 40, seen);
    checks++;
    if (!seen || coeff_out !== pat_bank('h40)) begin
      errors++;
      $display("FAIL overrun_swap: seen=%0d bank %h, required %h", seen, coeff_out, pat_bank('h40));
    end
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    resp_delay = 3;
  endtask

  task automatic test_enable_drop();
    bit seen;
    int starts;
    logic prev_s;
    pat_base = 'h80;
    exp_q.push_back(pat_bank('h80));
    enable = 1'b1;
    wait_sig(2, 40, seen);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (coeff_start && coeff_ch == 1'b1) break;
    end
    enable = 1'b0;
    wait_sig(0, 40, seen);
    checks++;
    if (!seen || coeff_out !== pat_bank('h80)) begin
      errors++;
      $display("FAIL enable_drop_swap: seen=%0d bank %h, required %h", seen, coeff_out, pat_bank('h80));
    end
    starts = 0;
    prev_s = 1'b0;
    for (int i = 0; i < 3*CLK_DIV; i++) begin
      @(negedge clk);
      if (coeff_start && !prev_s) starts++;
      prev_s = coeff_start;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL enable_drop_idle: got %0d starts, required 0", starts);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    pat_base = 'hA0;
    exp_q.push_back(pat_bank('hA0));
    exp_q.push_back(pat_bank('hC0));
    enable = 1'b1;
    wait_sig(1, 60, seen);
    pat_base = 'hC0;
    wait_sig(2, 40, seen);
    enable = 1'b0;
    checks++;
    if (!seen || bank_swap !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: start=%0d bank_swap=%b, required 1 and 1", seen, bank_swap);
    end
    wait_sig(1, 60, seen);
    wait_sig(0, 40, seen);
    checks++;
    if (!seen || coeff_out !== pat_bank('hC0) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_second: seen=%0d bank %h pending=%0d, required %h pending=0",
               seen, coeff_out, exp_q.size(), pat_bank('hC0));
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    enable = 1'b1;
    resp_en = 1'b0;
    wait_sig(2, 40, seen);
    enable = 1'b0;
`ifdef WAH_SEQ_TIMEOUT_EN
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!coeff_start) break;
      n++;
    end
    checks++;
    if (n != TMO || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: start high %0d cycles err=%b, required %0d and 1", n, timeout_err, TMO);
    end
    checks++;
    if (coeff_out !== pat_bank('hC0)) begin
      errors++;
      $display("FAIL timeout_bank_kept: got %h, required %h", coeff_out, pat_bank('hC0));
    end
    resp_en = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b, required 0", timeout_err);
    end
`else
    n = 0;
    repeat (3*TMO) @(negedge clk);
    checks++;
    if (coeff_start !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog: start=%b err=%b, required 1 and 0", coeff_start, timeout_err);
    end
    pat_base = 'h30;
    exp_q.push_back(pat_bank('h30));
    resp_en = 1'b1;
    wait_sig(0, 60, seen);
    checks++;
    if (!seen || coeff_out !== pat_bank('h30) || overrun !== 1'b1) begin
      errors++;
      $display("FAIL late_ready_swap: seen=%0d bank %h overrun=%b, required %h overrun=1",
               seen, coeff_out, overrun, pat_bank('h30));
    end
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    n = 0;
`endif
  endtask

  task automatic test_reset_mid_round();
    bit seen;
    int n;
    pat_base = 'hE0;
    enable = 1'b1;
    wait_sig(2, 40, seen);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sample_tick, coeff_start, bank_swap, ready_out, overrun, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b, required 000000",
               {sample_tick, coeff_start, bank_swap, ready_out, overrun, timeout_err});
    end
    checks++;
    if (coeff_out !== ident()) begin
      errors++;
      $display("FAIL async_reset_bank: got %h, required %h", coeff_out, ident());
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (coeff_start) begin
        seen = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    checks++;
    if (!seen || n != CLK_DIV + 1) begin
      errors++;
      $display("FAIL resume_start: seen=%0d at cycle %0d, required cycle %0d", seen, n, CLK_DIV + 1);
    end
    exp_q.push_back(pat_bank('hE0));
    wait_sig(0, 40, seen);
    checks++;
    if (!seen || coeff_out !== pat_bank('hE0)) begin
      errors++;
      $display("FAIL resume_swap: seen=%0d bank %h, required %h", seen, coeff_out, pat_bank('hE0));
    end
  endtask

  initial begin
    test_reset();
    test_round();
    test_overrun();
    test_enable_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid_round();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_swaps: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
